// File: rtl/gtxe2_chnl_tx_oob_if.sv
// Line-side bundle of the GTXE2 TX OOB generator: OOB requests, idle/data inputs,
// differential line outputs and status. The DUT takes the slave side.
interface gtxe2_chnl_tx_oob_if;
    logic       TXCOMINIT;
    logic       TXCOMWAKE;
    logic       TXELECIDLE;
    logic       data_serial;
    logic       TXP;
    logic       TXN;
    logic       TXCOMFINISH;
    logic       oob_busy;
    logic [1:0] state_dbg;

    // Requests are level-sampled on each clk edge. No backpressure is offered.
    // A request seen while oob_busy=1 is dropped, not queued.
    modport master (
        output TXCOMINIT, TXCOMWAKE, TXELECIDLE, data_serial,
        input  TXP, TXN, TXCOMFINISH, oob_busy, state_dbg
    );
    modport slave (
        input  TXCOMINIT, TXCOMWAKE, TXELECIDLE, data_serial,
        output TXP, TXN, TXCOMFINISH, oob_busy, state_dbg
    );
endinterface

// File: rtl/gtxe2_chnl_tx_oob.sv
// SATA OOB (COMINIT/COMWAKE) burst generator for the GTXE2 TX path.
// All outputs are registered from the next-state decode, so a request at edge k shows at k+1.
module gtxe2_chnl_tx_oob #(
    parameter int burst_len     = 240,
    parameter int wake_idle_len = 240,
    parameter int init_idle_len = 720,
    parameter int bursts_num    = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    gtxe2_chnl_tx_oob_if.slave     bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, GAP = 2'd2, FIN = 2'd3} state_t;

    localparam logic [15:0] BURST_LAST = 16'(burst_len - 1);
    localparam logic [15:0] WAKE_LAST  = 16'(wake_idle_len - 1);
    localparam logic [15:0] INIT_LAST  = 16'(init_idle_len - 1);
    localparam logic [2:0]  LAST_BURST = 3'(bursts_num - 1);

    state_t      state, state_nxt;
    logic [15:0] len_cnt, len_cnt_nxt;
    logic [2:0]  burst_cnt, burst_cnt_nxt;
    logic        kind, kind_nxt;
    logic        burst_phase, burst_phase_nxt;
    logic        txp_q, txn_q, fin_q, busy_q;
    logic        txp_nxt, txn_nxt, fin_nxt, busy_nxt;
    logic [15:0] gap_last;
    logic        req;

    assign req      = bus.TXCOMINIT | bus.TXCOMWAKE;
    assign gap_last = kind ? INIT_LAST : WAKE_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            len_cnt     <= '0;
            burst_cnt   <= '0;
            kind        <= 1'b0;
            burst_phase <= 1'b0;
            txp_q       <= 1'b0;
            txn_q       <= 1'b0;
            fin_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            len_cnt     <= len_cnt_nxt;
            burst_cnt   <= burst_cnt_nxt;
            kind        <= kind_nxt;
            burst_phase <= burst_phase_nxt;
            txp_q       <= txp_nxt;
            txn_q       <= txn_nxt;
            fin_q       <= fin_nxt;
            busy_q      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        len_cnt_nxt   = len_cnt;
        burst_cnt_nxt = burst_cnt;
        kind_nxt      = kind;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt     = BURST;
                    kind_nxt      = bus.TXCOMINIT;  // init wins when both are high
                    len_cnt_nxt   = '0;
                    burst_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (len_cnt == BURST_LAST) begin
                    state_nxt   = GAP;
                    len_cnt_nxt = '0;
                end else begin
                    len_cnt_nxt = len_cnt + 16'd1;
                end
            end
            GAP: begin
                if (len_cnt == gap_last) begin
                    len_cnt_nxt   = '0;
                    burst_cnt_nxt = burst_cnt + 3'd1;
                    state_nxt     = (burst_cnt == LAST_BURST) ? FIN : BURST;
                end else begin
                    len_cnt_nxt = len_cnt + 16'd1;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        txp_nxt         = 1'b0;
        txn_nxt         = 1'b0;
        fin_nxt         = 1'b0;
        busy_nxt        = 1'b0;
        burst_phase_nxt = 1'b0;
        case (state_nxt)
            IDLE: begin
                txp_nxt = ~bus.TXELECIDLE & bus.data_serial;
                txn_nxt = ~bus.TXELECIDLE & ~bus.data_serial;
            end
            BURST: begin
                // Every burst opens with phase 1, then alternates each cycle.
                burst_phase_nxt = (state == BURST) ? ~burst_phase : 1'b1;
                txp_nxt         = burst_phase_nxt;
                txn_nxt         = ~burst_phase_nxt;
                busy_nxt        = 1'b1;
            end
            GAP: busy_nxt = 1'b1;
            FIN: begin
                fin_nxt  = 1'b1;
                busy_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.TXP         = txp_q;
    assign bus.TXN         = txn_q;
    assign bus.TXCOMFINISH = fin_q;
    assign bus.oob_busy    = busy_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_gtxe2_chnl_tx_oob.sv
// Directed/randomized bench for gtxe2_chnl_tx_oob against a cycle-index waveform model.
module tb_gtxe2_chnl_tx_oob;
    localparam int B  = 240;
    localparam int WG = 240;
    localparam int IG = 720;
    localparam int N  = 6;

    logic clk = 1'b0;
    logic reset;

    gtxe2_chnl_tx_oob_if bus ();

    gtxe2_chnl_tx_oob #(
        .burst_len(B), .wake_idle_len(WG), .init_idle_len(IG), .bursts_num(N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_assert  = 0;
    int n_fail    = 0;
    int fin_count = 0;
    bit m_active  = 1'b0;
    bit m_kind    = 1'b0;
    int m_t       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input bit ci, input bit cw);
        bus.TXCOMINIT = ci;
        bus.TXCOMWAKE = cw;
    endtask

    task automatic rand_line();
        bus.TXELECIDLE  = 1'($urandom_range(0, 1));
        bus.data_serial = 1'($urandom_range(0, 1));
    endtask

    // One clock: capture inputs, advance the model, compare the cycle after the edge.
    task automatic step();
        bit   ci, cw, ei, d;
        int   gap, total, seg;
        logic ep, en, ef, eb;
        ci = bus.TXCOMINIT;
        cw = bus.TXCOMWAKE;
        ei = bus.TXELECIDLE;
        d  = bus.data_serial;
        @(posedge clk);
        if (m_active) begin
            m_t++;
            gap = m_kind ? IG : WG;
            if (m_t == N * (B + gap) + 2) m_active = 1'b0;
        end else if (ci || cw) begin
            m_active = 1'b1;
            m_t      = 1;
            m_kind   = ci;
        end
        if (m_active) begin
            gap   = m_kind ? IG : WG;
            total = N * (B + gap);
            eb    = 1'b1;
            if (m_t <= total) begin
                seg = (m_t - 1) % (B + gap);
                ef  = 1'b0;
                if (seg < B) begin
                    ep = (seg % 2 == 0);
                    en = ~ep;
                end else begin
                    ep = 1'b0;
                    en = 1'b0;
                end
            end else begin
                ep = 1'b0;
                en = 1'b0;
                ef = 1'b1;
            end
        end else begin
            eb = 1'b0;
            ef = 1'b0;
            ep = ei ? 1'b0 : d;
            en = ei ? 1'b0 : ~d;
        end
        #1;
        check("txp", bus.TXP, ep);
        check("txn", bus.TXN, en);
        check("comfinish", bus.TXCOMFINISH, ef);
        check("oob_busy", bus.oob_busy, eb);
        if (bus.TXCOMFINISH === 1'b1) fin_count++;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            rand_line();
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        set_req(1'b0, 1'b0);
        bus.TXELECIDLE  = 1'b1;
        bus.data_serial = 1'b0;
        #12;
        check("rst_txp", bus.TXP, 1'b0);
        check("rst_txn", bus.TXN, 1'b0);
        check("rst_fin", bus.TXCOMFINISH, 1'b0);
        check("rst_busy", bus.oob_busy, 1'b0);
        check("rst_state", bus.state_dbg, 2'd0);
        reset = 1'b0;
        step();

        // Idle passthrough: 1,0,1,1 then electrical idle, then random line.
        bus.TXELECIDLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.data_serial = (i == 1) ? 1'b0 : 1'b1;
            step();
        end
        bus.TXELECIDLE = 1'b1;
        step();
        step();
        run_random(20);

        // COMWAKE single-cycle request.
        fin_count = 0;
        set_req(1'b0, 1'b1);
        rand_line();
        step();
        set_req(1'b0, 1'b0);
        run_random(2881 + 3);
        check("wake_fin_count", fin_count, 1);

        // COMINIT single-cycle request.
        fin_count = 0;
        set_req(1'b1, 1'b0);
        step();
        set_req(1'b0, 1'b0);
        run_random(5761 + 3);
        check("init_fin_count", fin_count, 1);

        // Both requests together, plus a stray COMWAKE mid-sequence.
        fin_count = 0;
        set_req(1'b1, 1'b1);
        step();
        for (int i = 1; i <= 5765; i++) begin
            set_req(1'b0, i == 1000);
            rand_line();
            step();
        end
        check("both_fin_count", fin_count, 1);

        // COMWAKE held high: sequences restart back-to-back after each FIN.
        fin_count = 0;
        set_req(1'b0, 1'b1);
        run_random(5770);
        set_req(1'b0, 1'b0);
        run_random(2900);
        check("held_fin_count", fin_count, 3);

        // Asynchronous reset at cycle 1500 of a wake sequence.
        fin_count = 0;
        set_req(1'b0, 1'b1);
        step();
        set_req(1'b0, 1'b0);
        run_random(1499);
        check("pre_rst_busy", bus.oob_busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_txp", bus.TXP, 1'b0);
        check("arst_txn", bus.TXN, 1'b0);
        check("arst_busy", bus.oob_busy, 1'b0);
        check("arst_fin", bus.TXCOMFINISH, 1'b0);
        m_active = 1'b0;
        #1;
        reset = 1'b0;
        run_random(5);
        check("abort_fin_count", fin_count, 0);
        set_req(1'b0, 1'b1);
        step();
        set_req(1'b0, 1'b0);
        run_random(2881 + 3);
        check("after_rst_fin_count", fin_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/gtxe2_chnl_tx_oob.md
Name: gtxe2_chnl_tx_oob

Overview:
- SATA OOB signal generator for the GTXE2 channel TX path; the stage that produces the OOB waveform consumed by the channel RX OOB detector.
- Emits COMINIT/COMWAKE as a fixed number of differential bursts separated by electrical-idle gaps.
- Otherwise passes serial data through, or holds electrical idle.
- Timing is counted in clk cycles; defaults sit inside the detector acceptance windows: burst 150..340, wake idle 150..340, init idle 450..990.

Parameters:
- burst_len, 240, burst duration in clk cycles (1..65535)
- wake_idle_len, 240, COMWAKE gap duration in clk cycles (1..65535)
- init_idle_len, 720, COMINIT gap duration in clk cycles (1..65535)
- bursts_num, 6, bursts per sequence (1..7)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- TXCOMINIT  input  1  COMINIT request, sampled on clk
- TXCOMWAKE  input  1  COMWAKE request, sampled on clk
- TXELECIDLE  input  1  force electrical idle when no OOB sequence is running
- data_serial  input  1  serial data bit for normal transmission
- TXP  output  1  positive line
- TXN  output  1  negative line
- TXCOMFINISH  output  1  one-cycle pulse after the sequence completes
- oob_busy  output  1  high while an OOB sequence is in progress

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, reset). All registers clear immediately when reset asserts:
  - state=IDLE, len_cnt=0, burst_cnt=0, kind=0, burst_phase=0.
  - Outputs: TXP=0, TXN=0, TXCOMFINISH=0, oob_busy=0.
- Reset asserted mid-sequence aborts the sequence; no TXCOMFINISH is issued.
- All outputs are registered.
- States: IDLE, BURST, GAP, FIN.
- IDLE:
  - TXCOMINIT or TXCOMWAKE high at an edge -> BURST at that edge.
  - kind latched: 1=init, 0=wake. Both high -> init wins.
  - len_cnt=0, burst_cnt=0.
- BURST:
  - TXP=burst_phase, TXN=~burst_phase; burst_phase toggles every cycle, starting at 1 on the first BURST cycle. TXP!=TXN throughout.
  - len_cnt counts 0..burst_len-1; at burst_len-1 -> GAP, len_cnt=0.
- GAP:
  - TXP=TXN=0.
  - Gap length = kind ? init_idle_len : wake_idle_len.
  - At the last gap cycle: burst_cnt+1; if it equals bursts_num -> FIN, else -> BURST.
- FIN: TXCOMFINISH=1 for exactly one cycle, then -> IDLE.
- oob_busy is high in BURST, GAP and FIN.
- Requests arriving in BURST/GAP/FIN are ignored, not queued. A request held high across FIN restarts a new sequence from IDLE on the following edge.
- Outside OOB (IDLE), the line outputs are registered one cycle:
  - TXELECIDLE=1: TXP=TXN=0.
  - TXELECIDLE=0: TXP=data_serial, TXN=~data_serial.
  - TXELECIDLE is ignored while oob_busy=1.
- Latency: request sampled at edge k -> first burst cycle on outputs at k+1.
- Sequence length in cycles is bursts_num*(burst_len+gap_len). TXCOMFINISH appears in the cycle after the final gap.
- Width rules: len_cnt 16 bit, burst_cnt 3 bit; neither counter wraps within legal parameter ranges.

Test Plan:
- Reset, then one-cycle TXCOMWAKE at edge 0 -> bursts on cycles 1..240, 481..720, ...; gaps on 241..480, ...; last gap ends at cycle 2880; TXCOMFINISH=1 only at cycle 2881; oob_busy high on 1..2881.
- One-cycle TXCOMINIT at edge 0 -> 6 bursts of 240 and gaps of 720; TXCOMFINISH only at cycle 5761; TXP!=TXN on every burst cycle, TXP==TXN==0 on every gap cycle.
- TXCOMINIT and TXCOMWAKE together -> init timing (720-cycle gaps); TXCOMWAKE pulsed at cycle 1000 mid-sequence -> no effect, finish still at 5761.
- Loopback TXP/TXN into the RX OOB detector -> wake sequence gives exactly one RXCOMWAKEDET and no RXCOMINITDET; init sequence gives exactly one RXCOMINITDET and no RXCOMWAKEDET.
- Reset pulsed asynchronously (between edges) at cycle 1500 of a wake sequence -> TXP=TXN=0 and oob_busy=0 immediately; no TXCOMFINISH; a new TXCOMWAKE after reset produces a full sequence.
- IDLE with TXELECIDLE=0 and data_serial pattern 1,0,1,1 -> TXP follows one cycle later with TXN=~TXP; TXELECIDLE=1 -> TXP=TXN=0 one cycle later.
